// File: rtl/operand_shifter.sv
// operand_shifter: multi-cycle one-bit-per-clock LSL/LSR/ASR/ROR stage feeding the 33-bit ALU b operand
// shifterOut bit WIDTH is tied low so ALU carry/borrow detection at bit 32 stays clean.
module operand_shifter #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [1:0]       shiftType,
    input  logic [CNT_W-1:0] shiftAmount,
    input  logic [WIDTH-1:0] dataIn,
    input  logic             carryIn,
    output logic             busy,
    output logic             done,
    output logic [WIDTH:0]   shifterOut,
    output logic             shifterCarry
);
    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
    localparam logic [1:0] LSL = 2'b00, LSR = 2'b01, ASR = 2'b10;
    state_t           state;
    logic [1:0]       typ;
    logic [CNT_W-1:0] cnt;
    logic [WIDTH-1:0] r;
    logic             c;
    logic [WIDTH-1:0] nxt_r;
    logic             nxt_c;
    always_comb begin
        nxt_r = typ == LSL ? {r[WIDTH-2:0], 1'b0}
                           : {(typ == LSR ? 1'b0 : typ == ASR ? r[WIDTH-1] : r[0]), r[WIDTH-1:1]};
        nxt_c = typ == LSL ? r[WIDTH-1] : r[0];
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            typ   <= LSL;
            cnt   <= '0;
            r     <= '0;
            c     <= 1'b0;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            case (state)
                IDLE: if (start) begin
                    r     <= dataIn;
                    typ   <= shiftType;
                    cnt   <= shiftAmount;
                    c     <= carryIn;
                    busy  <= 1'b1;
                    done  <= shiftAmount == '0;
                    state <= shiftAmount == '0 ? DONE : SHIFT;
                end
                SHIFT: begin
                    r   <= nxt_r;
                    c   <= nxt_c;
                    cnt <= cnt - 1'b1;
                    if (cnt == CNT_W'(1)) begin
                        done  <= 1'b1;
                        state <= DONE;
                    end
                end
                default: begin
                    busy  <= 1'b0;
                    done  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end
    assign shifterOut   = {1'b0, r};
    assign shifterCarry = c;
endmodule
